// File: rtl/data_mem_line_ctrl_pkg.sv
// ============================================================================
// data_mem_line_ctrl_pkg : shared line geometry, address map and state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package data_mem_line_ctrl_pkg;

    localparam int CACHE_WORD_BITS     = 32;
    localparam int CACHE_LINE_WORDS    = 4;
    localparam int CACHE_LINE_BITS     = CACHE_WORD_BITS * CACHE_LINE_WORDS;
    localparam int CACHE_LINE_OFF_BITS = $clog2(CACHE_LINE_WORDS) + 2;

    localparam int ADDR_BITS           = 14;
    localparam int MEM_ADDR_BITS       = 10;
    localparam logic [ADDR_BITS-1:0] MEM_BASE_DEFAULT = 14'h1000;
    localparam int DEPTH_WORDS_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        RD   = 3'd2,
        LAST = 3'd3,
        RESP = 3'd4
    } state_e;

    // A one-word line still needs a one-bit beat register.
    function automatic int beat_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_line_ctrl.sv
// ============================================================================
// data_mem_line_ctrl : serialises a cache miss (optional write-back + refill)
// into word accesses on a 1-cycle-latency single-port RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_line_ctrl
    import data_mem_line_ctrl_pkg::*;
#(
    parameter int                   LINE_WORDS  = CACHE_LINE_WORDS,
    parameter int                   DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter logic [ADDR_BITS-1:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_evict,
    input  logic [ADDR_BITS-1:0]             evict_addr,
    input  logic [CACHE_WORD_BITS*LINE_WORDS-1:0] evict_data,
    input  logic [ADDR_BITS-1:0]             fill_addr,
    output logic                             fill_valid,
    output logic [CACHE_WORD_BITS*LINE_WORDS-1:0] fill_data,
    output logic                             fill_err,
    output logic                             busy,
    output logic [MEM_ADDR_BITS-1:0]         mem_addr,
    output logic                             mem_we,
    output logic [CACHE_WORD_BITS-1:0]       mem_wdata,
    input  logic [CACHE_WORD_BITS-1:0]       mem_rdata
);

    localparam int                LINE_BITS  = CACHE_WORD_BITS * LINE_WORDS;
    localparam int                BEAT_W     = beat_width(LINE_WORDS);
    localparam int                IDX_W      = ADDR_BITS - 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  ALIGN_MASK = ~IDX_W'(LINE_WORDS - 1);

    function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_BITS-1:0] addr);
        return IDX_W'((addr - MEM_BASE) >> 2) & ALIGN_MASK;
    endfunction

    function automatic logic [MEM_ADDR_BITS-1:0] mem_index(input logic [ADDR_BITS-1:0] addr);
        return MEM_ADDR_BITS'(line_index(addr));
    endfunction

    function automatic logic in_range(input logic [ADDR_BITS-1:0] addr);
        logic [31:0] line_end;
        line_end = 32'(line_index(addr)) + 32'(LINE_WORDS);
        return (addr >= MEM_BASE) && (line_end <= 32'(DEPTH_WORDS));
    endfunction

    state_e                   state_q,     state_d;
    logic [BEAT_W-1:0]        beat_q,      beat_d;
    logic [LINE_BITS-1:0]     evict_q,     evict_d;
    logic [MEM_ADDR_BITS-1:0] eidx_q,      eidx_d;
    logic [MEM_ADDR_BITS-1:0] fidx_q,      fidx_d;
    logic                     fok_q,       fok_d;
    logic                     err_q,       err_d;
    logic [LINE_BITS-1:0]     buf_q,       buf_d;
    logic [LINE_BITS-1:0]     fill_data_q, fill_data_d;
    logic                     fill_err_q,  fill_err_d;

    logic                     w_beat_last;
    logic [BEAT_W-1:0]        w_prev_beat;
    logic                     w_evict_ok;
    logic                     w_fill_ok;

    assign w_beat_last = (beat_q == LAST_BEAT);
    assign w_prev_beat = beat_q - BEAT_W'(1);
    assign w_evict_ok  = in_range(evict_addr);
    assign w_fill_ok   = in_range(fill_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            evict_q     <= '0;
            eidx_q      <= '0;
            fidx_q      <= '0;
            fok_q       <= 1'b0;
            err_q       <= 1'b0;
            buf_q       <= '0;
            fill_data_q <= '0;
            fill_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            evict_q     <= evict_d;
            eidx_q      <= eidx_d;
            fidx_q      <= fidx_d;
            fok_q       <= fok_d;
            err_q       <= err_d;
            buf_q       <= buf_d;
            fill_data_q <= fill_data_d;
            fill_err_q  <= fill_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        evict_d     = evict_q;
        eidx_d      = eidx_q;
        fidx_d      = fidx_q;
        fok_d       = fok_q;
        err_d       = err_q;
        buf_d       = buf_q;
        fill_data_d = fill_data_q;
        fill_err_d  = fill_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    evict_d = evict_data;
                    eidx_d  = mem_index(evict_addr);
                    fidx_d  = mem_index(fill_addr);
                    fok_d   = w_fill_ok;
                    err_d   = (req_evict && !w_evict_ok) || !w_fill_ok;
                    buf_d   = '0;
                    beat_d  = '0;
                    state_d = (req_evict && w_evict_ok) ? WB : RD;
                end
            end
            WB: begin
                if (w_beat_last) begin
                    beat_d  = '0;
                    state_d = RD;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end
            RD: begin
                // RAM data lags its address by one beat.
                if (fok_q && (beat_q != '0)) begin
                    buf_d[int'(w_prev_beat)*CACHE_WORD_BITS +: CACHE_WORD_BITS] = mem_rdata;
                end
                if (w_beat_last) begin
                    beat_d  = '0;
                    state_d = LAST;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end
            LAST: begin
                fill_data_d = buf_q;
                if (fok_q) begin
                    fill_data_d[(LINE_WORDS-1)*CACHE_WORD_BITS +: CACHE_WORD_BITS] = mem_rdata;
                end
                fill_err_d = err_q;
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM strobes decode straight from state so reset kills a write at once.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WB) begin
            mem_we    = 1'b1;
            mem_addr  = eidx_q + MEM_ADDR_BITS'(beat_q);
            mem_wdata = evict_q[int'(beat_q)*CACHE_WORD_BITS +: CACHE_WORD_BITS];
        end else if ((state_q == RD) && fok_q) begin
            mem_addr  = fidx_q + MEM_ADDR_BITS'(beat_q);
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign fill_valid = (state_q == RESP);
    assign fill_data  = fill_data_q;
    assign fill_err   = fill_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_line_ctrl.sv
// ============================================================================
// tb_data_mem_line_ctrl : directed table, corner sequences and random requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_line_ctrl;

    localparam int LW    = 4;
    localparam int DEPTH = 1024;
    localparam int LB    = 32 * LW;
    localparam int BASE  = 32'h1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_evict;
    logic [13:0]   evict_addr, fill_addr;
    logic [LB-1:0] evict_data, fill_data;
    logic          fill_valid, fill_err, busy;
    logic [9:0]    mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata, mem_rdata;

    logic          tb_we;
    logic [9:0]    tb_waddr;
    logic [31:0]   tb_wdata;

    logic [31:0]   ram     [DEPTH];
    logic [31:0]   exp_mem [DEPTH];

    int            checks   = 0;
    int            failures = 0;
    logic [LB-1:0] prev_fill;

    always #5 clk = ~clk;

    data_mem_line_ctrl #(
        .LINE_WORDS (LW),
        .DEPTH_WORDS(DEPTH),
        .MEM_BASE   (14'h1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_evict (req_evict),
        .evict_addr(evict_addr),
        .evict_data(evict_data),
        .fill_addr (fill_addr),
        .fill_valid(fill_valid),
        .fill_data (fill_data),
        .fill_err  (fill_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (tb_we)       ram[tb_waddr] <= tb_wdata;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Spec-level address rule: word index of the aligned line, and whether it fits.
    function automatic bit line_ok(input logic [13:0] a, output int widx);
        widx = 0;
        if (int'(a) < BASE) return 1'b0;
        widx = ((int'(a) - BASE) / 4 / LW) * LW;
        return (widx + LW <= DEPTH);
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] l;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 14'($urandom);
        return 14'(BASE + int'($urandom_range(0, 4095)));
    endfunction

    task automatic drive(input bit ev, input logic [13:0] ea, input logic [LB-1:0] ed,
                         input logic [13:0] fa);
        req_evict  = ev;
        evict_addr = ea;
        evict_data = ed;
        fill_addr  = fa;
        req_valid  = 1'b1;
    endtask

    // Called near a falling edge; returns just after the accepting rising edge.
    task automatic accept(output int waits);
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check_b("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor(input bit ev, input logic [13:0] ea, input logic [LB-1:0] ed,
                           input logic [13:0] fa, output int lat, output logic err_o,
                           output logic [LB-1:0] data_o);
        int eidx, fidx, nwb, lexp;
        bit eok, fok, wb, bus_ok, hs_ok, hold_ok, exp_err;
        logic [LB-1:0] exp_line;
        eok  = line_ok(ea, eidx);
        fok  = line_ok(fa, fidx);
        wb   = ev && eok;
        nwb  = wb ? LW : 0;
        lexp = nwb + LW + 2;
        if (wb) for (int k = 0; k < LW; k++) exp_mem[eidx + k] = ed[k*32 +: 32];
        exp_line = '0;
        if (fok) for (int k = 0; k < LW; k++) exp_line[k*32 +: 32] = exp_mem[fidx + k];
        exp_err = (ev && !eok) || !fok;
        lat = -1; bus_ok = 1; hs_ok = 1; hold_ok = 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || busy !== 1'b1) hs_ok = 0;
            if (c < lexp && fill_data !== prev_fill) hold_ok = 0;
            if (c <= nwb) begin
                if (mem_we !== 1'b1 || mem_addr !== 10'(eidx + c - 1) ||
                    mem_wdata !== ed[(c-1)*32 +: 32]) bus_ok = 0;
            end else if (c <= nwb + LW) begin
                if (mem_we !== 1'b0 || mem_addr !== (fok ? 10'(fidx + c - nwb - 1) : 10'd0))
                    bus_ok = 0;
            end else if (mem_we !== 1'b0) begin
                bus_ok = 0;
            end
            if (fill_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        err_o  = fill_err;
        data_o = fill_data;
        check("latency", LB'(lat), LB'(lexp));
        check("fill_data", fill_data, exp_line);
        check_b("fill_err", fill_err, exp_err);
        check_b("mem_bus", bus_ok, 1'b1);
        check_b("handshake", hs_ok, 1'b1);
        check_b("fill_hold", hold_ok, 1'b1);
        prev_fill = exp_line;
    endtask

    task automatic do_req(input bit ev, input logic [13:0] ea, input logic [LB-1:0] ed,
                          input logic [13:0] fa, output int lat, output logic err_o,
                          output logic [LB-1:0] data_o);
        int w;
        drive(ev, ea, ed, fa);
        accept(w);
        req_valid = 1'b0;
        monitor(ev, ea, ed, fa, lat, err_o, data_o);
    endtask

    typedef struct {
        bit            ev;
        logic [13:0]   ea;
        logic [LB-1:0] ed;
        logic [13:0]   fa;
        bit            exp_err;
        int            exp_lat;
        bit            chk_data;
        logic [LB-1:0] exp_data;
    } vec_t;

    vec_t vt [7];

    initial begin
        int            lat, w, eidx;
        logic          err;
        logic [LB-1:0] data, xa, xb, line_r, exp_line;
        bit            ok;

        req_valid = 0; req_evict = 0; evict_addr = '0; evict_data = '0; fill_addr = '0;
        tb_we = 0; tb_waddr = '0; tb_wdata = '0; prev_fill = '0;
        rst_n = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            tb_we    = 1'b1;
            tb_waddr = 10'(i);
            tb_wdata = (i >= 4 && i < 8) ? 32'((i - 3) * 32'h11) : $urandom;
            exp_mem[i] = tb_wdata;
        end
        @(negedge clk);
        tb_we = 1'b0;

        check_b("rst_req_ready", req_ready, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_fill_valid", fill_valid, 1'b0);
        check_b("rst_fill_err", fill_err, 1'b0);
        check("rst_fill_data", fill_data, '0);
        check_b("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", LB'(mem_addr), '0);
        check("rst_mem_wdata", LB'(mem_wdata), '0);

        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        xa = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        xb = rand_line();
        vt[0] = '{1'b0, 14'h0000, LB'(0), 14'h1010, 1'b0, 6,  1'b1,
                  {32'h44, 32'h33, 32'h22, 32'h11}};
        vt[1] = '{1'b1, 14'h1020, xa, 14'h1030, 1'b0, 10, 1'b0, LB'(0)};
        vt[2] = '{1'b1, 14'h1040, xb, 14'h1040, 1'b0, 10, 1'b1, xb};
        vt[3] = '{1'b1, 14'h0FF0, rand_line(), 14'h1000, 1'b1, 6, 1'b1,
                  {exp_mem[3], exp_mem[2], exp_mem[1], exp_mem[0]}};
        vt[4] = '{1'b0, 14'h0000, LB'(0), 14'h2FF4, 1'b1, 6,  1'b1, LB'(0)};
        vt[5] = '{1'b1, 14'h1100, rand_line(), 14'h3FFC, 1'b1, 10, 1'b1, LB'(0)};
        vt[6] = '{1'b0, 14'h1200, rand_line(), 14'h1200, 1'b0, 6,  1'b1,
                  {exp_mem[131], exp_mem[130], exp_mem[129], exp_mem[128]}};

        for (int i = 0; i < 7; i++) begin
            do_req(vt[i].ev, vt[i].ea, vt[i].ed, vt[i].fa, lat, err, data);
            check($sformatf("vec%0d_latency", i), LB'(lat), LB'(vt[i].exp_lat));
            check_b($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            if (vt[i].chk_data) check($sformatf("vec%0d_data", i), data, vt[i].exp_data);
        end

        // Back-to-back: second request held on req_valid during the first.
        xa = rand_line();
        drive(1'b1, 14'h1300, xa, 14'h1310);
        accept(w);
        drive(1'b0, 14'h0000, LB'(0), 14'h1300);
        monitor(1'b1, 14'h1300, xa, 14'h1310, lat, err, data);
        accept(w);
        check("b2b_accept_wait", LB'(w), LB'(1));
        req_valid = 1'b0;
        monitor(1'b0, 14'h0000, LB'(0), 14'h1300, lat, err, data);
        check("b2b_data", data, xa);

        // Reset while the third write-back beat is on the bus.
        line_r = rand_line();
        ok = line_ok(14'h1400, eidx);
        drive(1'b1, 14'h1400, line_r, 14'h1400);
        accept(w);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_b("wb_beat2_we", mem_we, 1'b1);
        check("wb_beat2_addr", LB'(mem_addr), LB'(eidx + 2));
        #1 rst_n = 1'b0;
        #1;
        check_b("arst_mem_we", mem_we, 1'b0);
        check_b("arst_busy", busy, 1'b0);
        check_b("arst_req_ready", req_ready, 1'b1);
        check("arst_fill_data", fill_data, '0);
        exp_mem[eidx]     = line_r[31:0];
        exp_mem[eidx + 1] = line_r[63:32];
        prev_fill = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        exp_line = {exp_mem[eidx + 3], exp_mem[eidx + 2], line_r[63:32], line_r[31:0]};
        do_req(1'b0, 14'h0000, LB'(0), 14'h1400, lat, err, data);
        check("arst_partial_line", data, exp_line);

        for (int i = 0; i < 40; i++) begin
            logic [13:0] ea, fa;
            bit          ev;
            ev = 1'($urandom_range(0, 1));
            ea = rand_addr();
            fa = ($urandom_range(0, 3) == 0) ? ea : rand_addr();
            do_req(ev, ea, rand_line(), fa, lat, err, data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
